flowcmd_gen: RTL and testbench



---
 rtl/flowcmd_pkg.sv | 45 ++++
 rtl/flowcmd_if.sv | 28 ++
 rtl/flowcmd_ipcsum.sv | 34 +++
 rtl/flowcmd_gen.sv | 140 ++++++++++++++
 tb/tb_flowcmd_gen.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/flowcmd_pkg.sv
// Shared constants, byte offsets and FSM state type for the flow-command frame generator.
// The IPv4 checksum datapath is built only when FLOWCMD_IPCSUM_EN is defined.
package flowcmd_pkg;

  localparam logic [31:0] MAGIC_CODE    = 32'hC0C0C0CC;
  localparam logic [15:0] CMD_UDP_PORT  = 16'd3776;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [7:0]  IP_TOS        = 8'h00;
  localparam logic [15:0] IP_TOTAL_LEN  = 16'd46;
  localparam logic [15:0] IP_FLAGS_FRAG = 16'h0000;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [15:0] UDP_LEN       = 16'd26;
  localparam logic [15:0] UDP_CSUM      = 16'h0000;

  localparam int FRAME_LEN  = 60;
  localparam int FRAME_BITS = FRAME_LEN * 8;
  localparam int PAD_BITS   = 80;

  // Byte offsets inside the frame
  localparam int OFF_DST_MAC  = 'h00;
  localparam int OFF_SRC_MAC  = 'h06;
  localparam int OFF_ETH_TYPE = 'h0c;
  localparam int OFF_IP_HDR   = 'h0e;
  localparam int OFF_IDENT    = 'h12;
  localparam int OFF_TTL      = 'h16;
  localparam int OFF_CSUM     = 'h18;
  localparam int OFF_SRC_IP   = 'h1a;
  localparam int OFF_DST_IP   = 'h1e;
  localparam int OFF_UDP      = 'h22;
  localparam int OFF_MAGIC    = 'h2a;
  localparam int OFF_PORTS    = 'h2e;
  localparam int OFF_PAD      = 'h32;

  localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);
  localparam logic [8:0] SEP_WORD = 9'h000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CSUM = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_e;

endpackage

// File: rtl/flowcmd_if.sv
// Command request and TX FIFO write bus of the flow-command frame generator.
// master = generator side, slave = requester / FIFO side.
interface flowcmd_if;
  import flowcmd_pkg::*;

  // Handshake: cmd_req is a level request; the generator samples it only while idle and
  // answers with a one-cycle cmd_ack on the edge that latches cmd_ports. cmd_busy spans
  // accept to separator write. tx_wr_en is a write strobe: it is only raised on an edge
  // where tx_full was sampled low, so a write is never issued into a full FIFO.
  logic        cmd_req;
  logic [31:0] cmd_ports;
  logic        cmd_ack;
  logic        cmd_busy;
  logic [8:0]  tx_din;
  logic        tx_wr_en;
  logic        tx_full;

  modport master (
    input  cmd_req, cmd_ports, tx_full,
    output cmd_ack, cmd_busy, tx_din, tx_wr_en
  );

  modport slave (
    output cmd_req, cmd_ports, tx_full,
    input  cmd_ack, cmd_busy, tx_din, tx_wr_en
  );

endinterface

// File: rtl/flowcmd_ipcsum.sv
// Combinational IPv4 header checksum over the fixed command header; only ident varies.
// Instantiated by flowcmd_gen when FLOWCMD_IPCSUM_EN is defined.
module flowcmd_ipcsum
  import flowcmd_pkg::*;
#(
  parameter logic [31:0] SRC_IP = 32'h0A000001,
  parameter logic [31:0] DST_IP = 32'h0A000002,
  parameter logic [7:0]  TTL    = 8'h40
) (
  input  logic [15:0] ident_i,
  output logic [15:0] csum_o
);

  logic [19:0] sum_w;
  logic [16:0] fold1_w;
  logic [15:0] fold2_w;

  // Checksum field itself contributes zero and is left out of the sum.
  always_comb begin
    sum_w   = 20'({IP_VER_IHL, IP_TOS})
            + 20'(IP_TOTAL_LEN)
            + 20'(ident_i)
            + 20'(IP_FLAGS_FRAG)
            + 20'({TTL, IP_PROTO_UDP})
            + 20'(SRC_IP[31:16])
            + 20'(SRC_IP[15:0])
            + 20'(DST_IP[31:16])
            + 20'(DST_IP[15:0]);
    fold1_w = 17'(sum_w[15:0]) + 17'(sum_w[19:16]);
    fold2_w = fold1_w[15:0] + 16'(fold1_w[16]);
    csum_o  = ~fold2_w;
  end

endmodule

// File: rtl/flowcmd_gen.sv
// Builds a 60-byte Ethernet/IPv4/UDP flow-command frame plus a 9'h000 separator into a
// 9-bit TX FIFO. Optional IPv4 header checksum via macro FLOWCMD_IPCSUM_EN.
module flowcmd_gen
  import flowcmd_pkg::*;
#(
  parameter logic [47:0] DST_MAC      = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC      = 48'h020000000001,
  parameter logic [31:0] SRC_IP       = 32'h0A000001,
  parameter logic [31:0] DST_IP       = 32'h0A000002,
  parameter logic [15:0] UDP_SRC_PORT = 16'd3776,
  parameter logic [7:0]  TTL          = 8'h40
) (
  input  logic      sys_clk,
  input  logic      sys_rst,
  flowcmd_if.master bus,
  output state_e    dbg_state_o
);

  state_e      state_q;
  logic [5:0]  idx_q;
  logic [15:0] ident_q;
  logic [31:0] ports_q;
  logic        ack_q;
  logic        busy_q;
  logic        wr_en_q;
  logic [8:0]  din_q;

  logic [15:0]         csum_field_w;
  logic [FRAME_BITS-1:0] frame_w;
  logic [7:0]          frame_b [FRAME_LEN];
  logic [7:0]          byte_w;

`ifdef FLOWCMD_IPCSUM_EN
  logic [15:0] csum_d;
  logic [15:0] csum_q;

  flowcmd_ipcsum #(
    .SRC_IP (SRC_IP),
    .DST_IP (DST_IP),
    .TTL    (TTL)
  ) u_ipcsum (
    .ident_i (ident_q),
    .csum_o  (csum_d)
  );

  // Captured in CSUM so the sum path is off the byte-mux path while sending.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      csum_q <= 16'h0000;
    end else if (state_q == S_CSUM) begin
      csum_q <= csum_d;
    end
  end

  assign csum_field_w = csum_q;
`else
  assign csum_field_w = 16'h0000;
`endif

  assign frame_w = {
    DST_MAC, SRC_MAC, ETH_TYPE_IPV4,
    IP_VER_IHL, IP_TOS, IP_TOTAL_LEN, ident_q, IP_FLAGS_FRAG,
    TTL, IP_PROTO_UDP, csum_field_w, SRC_IP, DST_IP,
    UDP_SRC_PORT, CMD_UDP_PORT, UDP_LEN, UDP_CSUM,
    MAGIC_CODE, ports_q, {PAD_BITS{1'b0}}
  };

  always_comb begin
    for (int i = 0; i < FRAME_LEN; i++) begin
      frame_b[i] = frame_w[FRAME_BITS-1-8*i -: 8];
    end
  end

  assign byte_w = frame_b[idx_q];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ident_q <= 16'h0000;
      ports_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      wr_en_q <= 1'b0;
      din_q   <= 9'h000;
    end else begin
      ack_q   <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (bus.cmd_req) begin
            ports_q <= bus.cmd_ports;
            ack_q   <= 1'b1;
            busy_q  <= 1'b1;
`ifdef FLOWCMD_IPCSUM_EN
            state_q <= S_CSUM;
`else
            state_q <= S_SEND;
`endif
          end
        end
        S_CSUM: begin
          state_q <= S_SEND;
        end
        S_SEND: begin
          if (!bus.tx_full) begin
            wr_en_q <= 1'b1;
            din_q   <= {1'b1, byte_w};
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              state_q <= S_GAP;
            end else begin
              idx_q <= idx_q + 6'd1;
            end
          end
        end
        S_GAP: begin
          // busy drops one edge later, in IDLE, unless a new request is taken there.
          if (!bus.tx_full) begin
            wr_en_q <= 1'b1;
            din_q   <= SEP_WORD;
            ident_q <= ident_q + 16'd1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ack  = ack_q;
  assign bus.cmd_busy = busy_q;
  assign bus.tx_wr_en = wr_en_q;
  assign bus.tx_din   = din_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_flowcmd_gen.sv
// Directed bench for flowcmd_gen: table of frame requests plus back-to-back and reset sequences.
// Expected latency and checksum bytes follow FLOWCMD_IPCSUM_EN.
module tb_flowcmd_gen;
  import flowcmd_pkg::*;

`ifdef FLOWCMD_IPCSUM_EN
  localparam int LAT_FIRST = 2;
  localparam int LAT_IDLE  = 63;
  localparam bit CSUM_ON   = 1'b1;
`else
  localparam int LAT_FIRST = 1;
  localparam int LAT_IDLE  = 62;
  localparam bit CSUM_ON   = 1'b0;
`endif

  typedef struct {
    logic [31:0] ports;
    int          stall_at;
    int          stall_len;
    logic [15:0] exp_ident;
    logic [15:0] exp_csum;
  } vec_t;

  logic   sys_clk = 1'b0;
  logic   sys_rst = 1'b1;
  state_e dbg_state;

  flowcmd_if bus ();

  flowcmd_gen dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  int   cyc = 0;
  logic full_at_edge = 1'b0;
  always @(posedge sys_clk) begin
    cyc          <= cyc + 1;
    full_at_edge <= bus.tx_full;
  end

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];
  int wr_cnt = 0;
  int ack_cnt = 0;
  int first_wr_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // scoreboard: every write is compared against the expected queue
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (bus.cmd_ack) ack_cnt++;
      if (bus.tx_wr_en) begin
        if (wr_cnt == 0) first_wr_cyc = cyc;
        wr_cnt++;
        check("write_while_full", full_at_edge, 1'b0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write actual=%h required=none", bus.tx_din);
        end else begin
          check("tx_din", bus.tx_din, exp_q.pop_front());
        end
      end
    end
  end

  function automatic void push_frame(input logic [15:0] id, input logic [15:0] cs,
                                     input logic [31:0] pm);
    logic [7:0] b [60];
    b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
          8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
          8'h08, 8'h00, 8'h45, 8'h00, 8'h00, 8'h2E,
          id[15:8], id[7:0], 8'h00, 8'h00, 8'h40, 8'h11,
          cs[15:8], cs[7:0],
          8'h0A, 8'h00, 8'h00, 8'h01, 8'h0A, 8'h00, 8'h00, 8'h02,
          8'h0E, 8'hC0, 8'h0E, 8'hC0, 8'h00, 8'h1A, 8'h00, 8'h00,
          8'hC0, 8'hC0, 8'hC0, 8'hCC,
          pm[31:24], pm[23:16], pm[15:8], pm[7:0],
          8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 60; i++) exp_q.push_back({1'b1, b[i]});
    exp_q.push_back(9'h000);
  endfunction

  // driver tasks
  task automatic start_req(input logic [31:0] pm, output int ack_cyc);
    ack_cyc = -1;
    bus.cmd_ports = pm;
    bus.cmd_req   = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge sys_clk);
      if (bus.cmd_ack) begin
        ack_cyc = cyc;
        break;
      end
    end
    bus.cmd_req   = 1'b0;
    bus.cmd_ports = ~pm;
    check("ack_seen", ack_cyc >= 0, 1'b1);
    check("busy_at_ack", bus.cmd_busy, 1'b1);
  endtask

  task automatic wait_idle(input int a, input int stall_at, input int stall_len,
                           output int low_cyc);
    low_cyc = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge sys_clk);
      if (cyc == a + stall_at) bus.tx_full = 1'b1;
      if (cyc == a + stall_at + stall_len) bus.tx_full = 1'b0;
      if (!bus.cmd_busy) begin
        low_cyc = cyc;
        break;
      end
    end
    bus.tx_full = 1'b0;
    check("busy_drop_seen", low_cyc >= 0, 1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    int a;
    int low;
    wr_cnt  = 0;
    ack_cnt = 0;
    push_frame(v.exp_ident, CSUM_ON ? v.exp_csum : 16'h0000, v.ports);
    start_req(v.ports, a);
    wait_idle(a, v.stall_at, v.stall_len, low);
    repeat (2) @(negedge sys_clk);
    check("first_wr_latency", first_wr_cyc - a, LAT_FIRST);
    check("write_count", wr_cnt, 61);
    check("busy_low_latency", low - a, LAT_IDLE + v.stall_len);
    check("ack_count", ack_cnt, 1);
    check("exp_q_left", exp_q.size(), 0);
  endtask

  vec_t vecs [3];

  initial begin
    int a1;
    int a2;
    int low;
    bit dropped;

    vecs[0] = '{ports: 32'h01020304, stall_at: -100, stall_len: 0,  exp_ident: 16'h0000, exp_csum: 16'h66BD};
    vecs[1] = '{ports: 32'hA55AFF00, stall_at: 10,   stall_len: 10, exp_ident: 16'h0001, exp_csum: 16'h66BC};
    vecs[2] = '{ports: 32'h80402010, stall_at: -100, stall_len: 0,  exp_ident: 16'h0002, exp_csum: 16'h66BB};

    bus.cmd_req   = 1'b0;
    bus.cmd_ports = 32'h0;
    bus.tx_full   = 1'b0;

    // reset state
    #22;
    check("rst_ack", bus.cmd_ack, 1'b0);
    check("rst_busy", bus.cmd_busy, 1'b0);
    check("rst_wr_en", bus.tx_wr_en, 1'b0);
    check("rst_din", bus.tx_din, 9'h000);
    check("rst_state", dbg_state, S_IDLE);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    for (int i = 0; i < 3; i++) run_vec(vecs[i]);

    // back-to-back: request held high across two frames, ports changed after first ack
    wr_cnt  = 0;
    ack_cnt = 0;
    dropped = 1'b0;
    push_frame(16'h0003, CSUM_ON ? 16'h66BA : 16'h0000, 32'h11223344);
    push_frame(16'h0004, CSUM_ON ? 16'h66B9 : 16'h0000, 32'h55667788);
    bus.cmd_ports = 32'h11223344;
    bus.cmd_req   = 1'b1;
    a1 = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge sys_clk);
      if (bus.cmd_ack) begin
        a1 = cyc;
        break;
      end
    end
    bus.cmd_ports = 32'h55667788;
    a2 = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge sys_clk);
      if (!bus.cmd_busy) dropped = 1'b1;
      if (bus.cmd_ack) begin
        a2 = cyc;
        break;
      end
    end
    bus.cmd_req   = 1'b0;
    bus.cmd_ports = 32'h0;
    wait_idle(a2, -100, 0, low);
    repeat (2) @(negedge sys_clk);
    check("b2b_ack_spacing", a2 - a1, LAT_IDLE);
    check("b2b_busy_gap", dropped, 1'b0);
    check("b2b_ack_count", ack_cnt, 2);
    check("b2b_write_count", wr_cnt, 122);
    check("b2b_busy_low", low - a2, LAT_IDLE);
    check("b2b_exp_q_left", exp_q.size(), 0);

    // reset mid-frame after byte 0x20 has been written
    wr_cnt = 0;
    push_frame(16'h0005, CSUM_ON ? 16'h66B8 : 16'h0000, 32'h0A0B0C0D);
    start_req(32'h0A0B0C0D, a1);
    for (int n = 0; n < 100; n++) begin
      @(negedge sys_clk);
      #1;
      if (wr_cnt >= 33) break;
    end
    check("pre_reset_writes", wr_cnt, 33);
    #2 sys_rst = 1'b1;
    #1;
    check("midrst_wr_en", bus.tx_wr_en, 1'b0);
    check("midrst_din", bus.tx_din, 9'h000);
    check("midrst_busy", bus.cmd_busy, 1'b0);
    check("midrst_state", dbg_state, S_IDLE);
    exp_q.delete();
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    run_vec('{ports: 32'hDEADBEEF, stall_at: -100, stall_len: 0, exp_ident: 16'h0000, exp_csum: 16'h66BD});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=done");
    $fatal(1, "bench did not complete");
  end

endmodule
